// File: rtl/mem_access_pkg.sv
// ============================================================================
// Module   : mem_access_pkg
// Brief    : Shared widths, FSM state encoding and strobe decode for the
//            memory access stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_access_pkg;

   localparam int MEM_ADDR_W = 20;
   localparam int MEM_DATA_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD       = 3'd1,
      ST_WR_SETUP = 3'd2,
      ST_WR_PULSE = 3'd3,
      ST_WR_HOLD  = 3'd4,
      ST_DONE     = 3'd5
   } mem_state_t;

   typedef struct packed {
      logic ce_n;
      logic oe_n;
      logic we_n;
      logic wdata_oe;
      logic ready;
      logic busy;
   } strobe_t;

   localparam strobe_t STROBE_IDLE = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1,
                                       wdata_oe: 1'b0, ready: 1'b0, busy: 1'b0};

   // Pin levels for a given state; applied to the state being entered.
   function automatic strobe_t decode_strobes(input mem_state_t st);
      strobe_t s;
      s = STROBE_IDLE;
      case (st)
         ST_RD: begin
            s.ce_n = 1'b0; s.oe_n = 1'b0; s.busy = 1'b1;
         end
         ST_WR_SETUP, ST_WR_HOLD: begin
            s.ce_n = 1'b0; s.wdata_oe = 1'b1; s.busy = 1'b1;
         end
         ST_WR_PULSE: begin
            s.ce_n = 1'b0; s.we_n = 1'b0; s.wdata_oe = 1'b1; s.busy = 1'b1;
         end
         ST_DONE: begin
            s.ready = 1'b1; s.busy = 1'b1;
         end
         default: s = STROBE_IDLE;
      endcase
      return s;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wait_counter.sv
// ============================================================================
// Module   : mem_wait_counter
// Brief    : Loadable down-counter with zero flag; saturates at zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wait_counter #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst)
         r_count <= '0;
      else if (load)
         r_count <= load_val;
      else if (dec && (r_count != '0))
         r_count <= r_count - 1'b1;
   end

   assign zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module   : mem_access_unit
// Brief    : MAR/MDR capture and fixed-latency async SRAM read/write sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int WAIT_CYCLES = 2,
   parameter int ADDR_W      = MEM_ADDR_W
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic [MEM_DATA_W-1:0] Bus,
   input  logic                  LD_MAR,
   input  logic                  LD_MDR,
   input  logic                  Mem_Req,
   input  logic                  Mem_RW,
   input  logic [MEM_DATA_W-1:0] Mem_Rdata,
   output logic [MEM_DATA_W-1:0] MAR_out,
   output logic [MEM_DATA_W-1:0] MDR_out,
   output logic [ADDR_W-1:0]     Mem_Addr,
   output logic [MEM_DATA_W-1:0] Mem_Wdata,
   output logic                  Mem_Wdata_OE,
   output logic                  Mem_CE_n,
   output logic                  Mem_OE_n,
   output logic                  Mem_WE_n,
   output logic                  Mem_Ready,
   output logic                  Busy
);

   localparam int               CNT_W    = $clog2(WAIT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

   mem_state_t            r_state;
   mem_state_t            w_next_state;
   strobe_t               r_strb;
   logic [MEM_DATA_W-1:0] r_mar;
   logic [MEM_DATA_W-1:0] r_mdr;
   logic                  w_cnt_load;
   logic                  w_cnt_dec;
   logic                  w_cnt_zero;

   mem_wait_counter #(
      .CNT_W (CNT_W)
   ) u_wait_counter (
      .clk      (Clk),
      .rst      (Reset),
      .load     (w_cnt_load),
      .load_val (CNT_LOAD),
      .dec      (w_cnt_dec),
      .zero     (w_cnt_zero)
   );

   always_comb begin
      w_next_state = r_state;
      w_cnt_load   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (Mem_Req) begin
               if (Mem_RW) begin
                  w_next_state = ST_WR_SETUP;
               end else begin
                  w_next_state = ST_RD;
                  w_cnt_load   = 1'b1;
               end
            end
         end
         ST_RD:       if (w_cnt_zero) w_next_state = ST_DONE;
         ST_WR_SETUP: begin
            w_next_state = ST_WR_PULSE;
            w_cnt_load   = 1'b1;
         end
         ST_WR_PULSE: if (w_cnt_zero) w_next_state = ST_WR_HOLD;
         ST_WR_HOLD:  w_next_state = ST_DONE;
         ST_DONE:     w_next_state = ST_IDLE;
         default:     w_next_state = ST_IDLE;
      endcase
   end

   assign w_cnt_dec = (r_state == ST_RD) || (r_state == ST_WR_PULSE);

   // Strobes are decoded from the next state so the pins come straight off flops.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state <= ST_IDLE;
         r_strb  <= STROBE_IDLE;
         r_mar   <= '0;
         r_mdr   <= '0;
      end else begin
         r_state <= w_next_state;
         r_strb  <= decode_strobes(w_next_state);
         if ((r_state == ST_IDLE) && LD_MAR)
            r_mar <= Bus;
         if ((r_state == ST_RD) && w_cnt_zero)
            r_mdr <= Mem_Rdata;
         else if ((r_state == ST_IDLE) && LD_MDR)
            r_mdr <= Bus;
      end
   end

   assign MAR_out      = r_mar;
   assign MDR_out      = r_mdr;
   assign Mem_Addr     = ADDR_W'(r_mar);
   assign Mem_Wdata    = r_mdr;
   assign Mem_Wdata_OE = r_strb.wdata_oe;
   assign Mem_CE_n     = r_strb.ce_n;
   assign Mem_OE_n     = r_strb.oe_n;
   assign Mem_WE_n     = r_strb.we_n;
   assign Mem_Ready    = r_strb.ready;
   assign Busy         = r_strb.busy;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module   : tb_mem_access_unit
// Brief    : Directed self-checking bench for mem_access_unit (WAIT_CYCLES=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [15:0] Bus;
   logic        LD_MAR;
   logic        LD_MDR;
   logic        Mem_Req;
   logic        Mem_RW;
   logic [15:0] Mem_Rdata;
   logic [15:0] MAR_out;
   logic [15:0] MDR_out;
   logic [19:0] Mem_Addr;
   logic [15:0] Mem_Wdata;
   logic        Mem_Wdata_OE;
   logic        Mem_CE_n;
   logic        Mem_OE_n;
   logic        Mem_WE_n;
   logic        Mem_Ready;
   logic        Busy;

   int n_cmp = 0;
   int n_err = 0;

   mem_access_unit #(
      .WAIT_CYCLES (2),
      .ADDR_W      (20)
   ) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .Bus          (Bus),
      .LD_MAR       (LD_MAR),
      .LD_MDR       (LD_MDR),
      .Mem_Req      (Mem_Req),
      .Mem_RW       (Mem_RW),
      .Mem_Rdata    (Mem_Rdata),
      .MAR_out      (MAR_out),
      .MDR_out      (MDR_out),
      .Mem_Addr     (Mem_Addr),
      .Mem_Wdata    (Mem_Wdata),
      .Mem_Wdata_OE (Mem_Wdata_OE),
      .Mem_CE_n     (Mem_CE_n),
      .Mem_OE_n     (Mem_OE_n),
      .Mem_WE_n     (Mem_WE_n),
      .Mem_Ready    (Mem_Ready),
      .Busy         (Busy)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled on the falling edge.
   task automatic step();
      @(negedge Clk);
   endtask

   int oe_lo, we_lo, rdy, rdy_at, busy_n, wd_bad, ce_bad;

   initial begin
      // Reset with garbage on every input
      Reset = 1'b1; Bus = 16'hFFFF; LD_MAR = 1'b1; LD_MDR = 1'b1;
      Mem_Req = 1'b1; Mem_RW = 1'b1; Mem_Rdata = 16'hDEAD;
      step();
      check("rst_mar", 32'(MAR_out), 32'h0);
      check("rst_mdr", 32'(MDR_out), 32'h0);
      check("rst_strobes", {29'd0, Mem_CE_n, Mem_OE_n, Mem_WE_n}, 32'h7);
      check("rst_ready_busy_oe", {29'd0, Mem_Ready, Busy, Mem_Wdata_OE}, 32'h0);
      Reset = 1'b0; LD_MAR = 1'b0; LD_MDR = 1'b0; Mem_Req = 1'b0; Mem_RW = 1'b0;

      // Read 0x3000 -> 0xBEEF
      Bus = 16'h3000; LD_MAR = 1'b1;
      step();
      LD_MAR = 1'b0; Mem_Req = 1'b1; Mem_RW = 1'b0; Mem_Rdata = 16'hBEEF;
      step();
      Mem_Req = 1'b0;
      check("rd_addr", 32'(Mem_Addr), 32'h03000);
      oe_lo = 0; rdy = 0; rdy_at = -1; busy_n = 0;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) step();
         if (!Mem_OE_n) oe_lo++;
         if (Busy) busy_n++;
         if (Mem_Ready) begin rdy++; rdy_at = i; end
      end
      check("rd_oe_cycles", 32'(oe_lo), 32'd2);
      check("rd_ready_count", 32'(rdy), 32'd1);
      check("rd_ready_cycle", 32'(rdy_at), 32'd2);
      check("rd_busy_cycles", 32'(busy_n), 32'd3);
      check("rd_mdr", 32'(MDR_out), 32'hBEEF);

      // Write 0x1234 to 0x0010
      Bus = 16'h0010; LD_MAR = 1'b1;
      step();
      LD_MAR = 1'b0; Bus = 16'h1234; LD_MDR = 1'b1;
      step();
      LD_MDR = 1'b0; Mem_Req = 1'b1; Mem_RW = 1'b1; Mem_Rdata = 16'h0F0F;
      step();
      Mem_Req = 1'b0; Mem_RW = 1'b0;
      we_lo = 0; rdy = 0; rdy_at = -1; busy_n = 0; wd_bad = 0; ce_bad = 0;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) step();
         if (!Mem_WE_n) begin
            we_lo++;
            if (i != 1 && i != 2) wd_bad++;
         end
         if (Busy) busy_n++;
         if (Mem_Ready) begin rdy++; rdy_at = i; end
         if (i <= 3 && (!Mem_Wdata_OE || Mem_Wdata != 16'h1234 || Mem_CE_n || !Mem_OE_n)) wd_bad++;
         if (i >= 4 && (Mem_Wdata_OE || !Mem_CE_n)) ce_bad++;
         if (i == 0) check("wr_setup_we", 32'(Mem_WE_n), 32'h1);
         if (i == 3) check("wr_hold_we", 32'(Mem_WE_n), 32'h1);
         if (i == 1) check("wr_addr", 32'(Mem_Addr), 32'h00010);
      end
      check("wr_we_cycles", 32'(we_lo), 32'd2);
      check("wr_bracket", 32'(wd_bad), 32'd0);
      check("wr_release", 32'(ce_bad), 32'd0);
      check("wr_ready_cycle", 32'(rdy_at), 32'd4);
      check("wr_ready_count", 32'(rdy), 32'd1);
      check("wr_busy_cycles", 32'(busy_n), 32'd5);
      check("wr_mdr_kept", 32'(MDR_out), 32'h1234);

      // Same-cycle LD_MAR with request, then loads attempted while busy
      Bus = 16'h00AA; LD_MAR = 1'b1; Mem_Req = 1'b1; Mem_RW = 1'b0; Mem_Rdata = 16'h5555;
      step();
      Mem_Req = 1'b0;
      check("same_cycle_addr", 32'(Mem_Addr), 32'h000AA);
      check("same_cycle_oe", 32'(Mem_OE_n), 32'h0);
      Bus = 16'h7777; LD_MAR = 1'b1; LD_MDR = 1'b1;
      step();
      step();
      LD_MAR = 1'b0; LD_MDR = 1'b0;
      check("busy_ready", 32'(Mem_Ready), 32'h1);
      check("busy_mar_held", 32'(MAR_out), 32'h00AA);
      check("busy_mdr_memwins", 32'(MDR_out), 32'h5555);
      step();

      // Mem_Req held through DONE launches a back-to-back read
      Mem_Req = 1'b1; Mem_RW = 1'b0; Mem_Rdata = 16'h1111;
      for (int i = 0; i < 5; i++) begin
         step();
         if (i == 2) Mem_Rdata = 16'h2222;
         if (i == 3) check("b2b_idle_gap", 32'(Busy), 32'h0);
         if (i == 4) begin
            check("b2b_restart_oe", 32'(Mem_OE_n), 32'h0);
            Mem_Req = 1'b0;
         end
      end
      step(); step(); step();
      check("b2b_mdr", 32'(MDR_out), 32'h2222);
      check("b2b_idle", 32'(Busy), 32'h0);

      // Reset asserted while WE_n is low
      Bus = 16'h4321; LD_MAR = 1'b1; Mem_Req = 1'b1; Mem_RW = 1'b1;
      step();
      LD_MAR = 1'b0; Mem_Req = 1'b0;
      step();
      check("midrst_pulse_we", 32'(Mem_WE_n), 32'h0);
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      check("midrst_we", 32'(Mem_WE_n), 32'h1);
      check("midrst_oe_busy", {30'd0, Mem_Wdata_OE, Busy}, 32'h0);
      check("midrst_ce", 32'(Mem_CE_n), 32'h1);
      check("midrst_mar", 32'(MAR_out), 32'h0);
      rdy = 0;
      for (int i = 0; i < 6; i++) begin
         if (Mem_Ready || Busy) rdy++;
         step();
      end
      check("midrst_no_ready", 32'(rdy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mem_access_unit.md
# mem_access_unit

Memory access stage sitting directly downstream of the datapath bus mux: it captures the bus into MAR/MDR, runs fixed-latency read/write cycles against the asynchronous SRAM, and feeds MAR_out/MDR_out back to the bus mux gate inputs. The control FSM starts a transaction with Mem_Req and waits for a one-cycle Mem_Ready (the classic "R" signal). All SRAM strobes are registered and glitch-free.

## Interface
- WAIT_CYCLES, 2: SRAM access cycles (strobe-active cycles per read / WE-low cycles per write); legal range 1..15
- ADDR_W, 20: SRAM address width; MAR (16 b) is zero-extended
- Clk  in  1  system clock, all logic on rising edge
- Reset  in  1  synchronous, active-high
- Bus  in  16  current datapath bus value
- LD_MAR  in  1  load MAR from Bus
- LD_MDR  in  1  load MDR from Bus
- Mem_Req  in  1  start transaction; sampled only in IDLE
- Mem_RW  in  1  0 = read, 1 = write; sampled with Mem_Req
- Mem_Rdata  in  16  SRAM read data
- MAR_out  out  16  MAR register to bus mux
- MDR_out  out  16  MDR register to bus mux
- Mem_Addr  out  ADDR_W  {zeros, MAR}
- Mem_Wdata  out  16  always equals MDR
- Mem_Wdata_OE  out  1  top-level tristate enable for data pins
- Mem_CE_n, Mem_OE_n, Mem_WE_n  out  1 each  active-low SRAM strobes
- Mem_Ready  out  1  one-cycle completion pulse
- Busy  out  1  high in every non-IDLE state

## Operation
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE: Mem_Req=1 & Mem_RW=0 -> RD; Mem_Req=1 & Mem_RW=1 -> WR_SETUP; else stay.
- RD: CE_n=0, OE_n=0, WE_n=1; held WAIT_CYCLES cycles; on the edge ending the last RD cycle, MDR <= Mem_Rdata; -> DONE.
- WR_SETUP (1 cycle): CE_n=0, OE_n=1, WE_n=1, Wdata_OE=1 -> WR_PULSE.
- WR_PULSE (WAIT_CYCLES cycles): as WR_SETUP but WE_n=0 -> WR_HOLD.
- WR_HOLD (1 cycle): WE_n=1, CE_n=0, Wdata_OE=1 -> DONE.
- DONE (1 cycle): all strobes inactive, Wdata_OE=0, Mem_Ready=1 -> IDLE.
- Strobes/Ready are registered outputs decoded from next state; no combinational path from inputs to SRAM pins.
- LD_MAR / LD_MDR honoured only in IDLE; ignored while Busy (address and write data stable through the transaction). LD_MDR also ignored on the RD capture edge (memory data wins).
- LD_MAR or LD_MDR in the same IDLE cycle as Mem_Req: register loads first; transaction uses the new value.
- Mem_Req must be deasserted by the control FSM in the Ready cycle; a request still high when IDLE is re-entered starts a new transaction.
- Reset (any state, including mid-transaction): next edge -> IDLE, MAR=0, MDR=0, CE_n=OE_n=WE_n=1, Wdata_OE=0, Mem_Ready=0, Busy=0, wait counter 0.

## Timing
- Request accepted at edge E0 (IDLE, Mem_Req=1).
- Read: strobes active cycles E0..E0+W (W=WAIT_CYCLES); MDR valid after edge E0+W; Mem_Ready high in cycle after E0+W; IDLE after E0+W+1. Total 2+W cycles request-to-IDLE.
- Write: WR_SETUP at E0, WE_n low W cycles, WR_HOLD, DONE; Mem_Ready high in cycle after edge E0+W+2; total W+3 cycles busy.
- Wait counter width: $clog2(WAIT_CYCLES+1); loaded W-1 on state entry, decrements, exits at 0; never wraps.

## Structure
- Package mem_access_pkg: state enum mem_state_t, MEM_ADDR_W=20, MEM_DATA_W=16.
- One sub-module natural: mem_wait_counter (load/decrement/zero flag), reused for RD and WR_PULSE.
- MAR/MDR registers and FSM in the top module; tristate buffer stays at top level.

## Test plan
- Reset: drive garbage, Reset=1 one cycle -> MAR_out=MDR_out=0, CE_n/OE_n/WE_n=1, Ready=0, Busy=0.
- Read, W=2: Bus=0x3000 LD_MAR, Mem_Req read, Mem_Rdata=0xBEEF -> Mem_Addr=0x03000, OE_n low 2 cycles, MDR_out=0xBEEF, one Ready pulse 3 cycles after accept.
- Write, W=2: MAR=0x0010, MDR=0x1234, Mem_Req write -> WE_n low exactly 2 cycles, bracketed by 1 setup and 1 hold cycle with Wdata_OE=1 and Mem_Wdata=0x1234; Ready after 5 cycles.
- Same-cycle load: LD_MAR Bus=0x00AA with Mem_Req read -> Mem_Addr=0x000AA from first strobe cycle.
- Busy interlock: LD_MAR/LD_MDR pulsed during read -> MAR unchanged, MDR ends = Mem_Rdata; Mem_Req held through DONE -> second transaction starts.
- Reset mid-write in WR_PULSE -> next cycle WE_n=1, Wdata_OE=0, IDLE, no Ready pulse.
